conv1d_ctrl: RTL and testbench
==============================

# conv1d_ctrl

Sequencing controller for the CONV1D datapath (4-lane int8 MAC with 32-bit accumulator). It fetches kernel and input words from a shared word-addressed memory, drives the datapath's register-load and reset strobes, and emits one 32-bit result per output position over a valid/ready port. It sits between the accelerator's register file and memory and the datapath instance.

## Interface
- AW, 10, memory word-address width
- LW, 8, width of word-count fields

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch job; sampled only in IDLE
- in_base  in  AW  word address of input vector
- ker_base  in  AW  word address of kernel vector
- n_words  in  LW  input length N in 32-bit words
- k_words  in  LW  kernel length K in 32-bit words
- mem_addr  out  AW  read address
- mem_rd  out  1  read strobe; data valid on in_data one cycle later (datapath side)
- reg_in_ld, reg_ker_ld, reg_sum_ld  out  1  datapath load strobes
- alu_rst_n, reg_sum_rst_n  out  1  datapath active-low resets
- result  in  32  datapath accumulator value
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  32  result
- out_idx  out  LW  output position j
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky until next start; set on illegal lengths

## Operation
- Semantics: out[j] = Σ_{k=0..K-1} dot4(in[j+k], ker[k]), j = 0..N-K; lanes are signed int8, byte 0 = bits [7:0].
- States: IDLE, CLR, RD_KER, RD_IN, LD_IN, ACC, WR, FIN.
- IDLE: start=1 latches bases/lengths, clears err. If K=0 or K>N → FIN with err=1 (no memory reads, no outputs); else j=0 → CLR.
- CLR: reg_sum_rst_n=0 for one cycle; k=0 → RD_KER.
- RD_KER: mem_rd=1, mem_addr=ker_base+k.
- RD_IN: reg_ker_ld=1; mem_rd=1, mem_addr=in_base+j+k.
- LD_IN: reg_in_ld=1.
- ACC: reg_sum_ld=1. If k<K-1: k++ → RD_KER; else → WR.
- WR: out_valid=1, out_data=result, out_idx=j. Holds until out_ready=1. On accept: if j<N-K, j++ → CLR; else → FIN.
- FIN: done=1 for one cycle → IDLE.
- Address arithmetic wraps modulo 2^AW. j and k counters are LW bits wide.
- All strobes are decoded from the registered state. Strobes not listed for a state are 0, active-low resets are 1, and mem_addr=0.
- busy=1 in every state except IDLE.
- start is ignored while busy. Latched parameters do not follow input changes mid-job.

## Timing
- rst=1: state←IDLE, j=k=0, err=0. While rst=1, alu_rst_n and reg_sum_rst_n are driven 0 combinationally to clear the datapath. All other outputs are 0.
- Reset mid-job aborts immediately: no done, no further out_valid.
- Start accepted at edge t → CLR at t+1 → first mem_rd at t+2.
- Per output: 1 (CLR) + 4K + W cycles, where W ≥ 1 is the number of WR cycles.
- First out_valid at t+2+4K.
- Illegal-length job: FIN at t+1, done at t+1, then IDLE.
- out_data/out_idx are stable while out_valid=1 and out_ready=0. The result register is not loaded in WR.
- done never coincides with out_valid.

## Configuration
- CONV1D_CTRL_RELU_EN defined: out_data = (result[31] ? 0 : result), i.e. ReLU.
- Undefined: out_data = result unmodified.
- No other behaviour or timing changes.

## Test plan
- Basic job: N=4, K=2; ker = {0x01010101, 0x02020202}; in = {0x01020304, 0x05060708, 0xFFFFFFFF, 0x7F7F7F7F}. Expect out_idx 0,1,2 with out_data 62, 18, 1012; first out_valid 10 cycles after start; then done pulse.
- Back-pressure: same job with out_ready held 0 for 5 cycles on each result. Data and index stay stable; no extra memory reads; values unchanged.
- Illegal lengths: K=0 → done at start+1, err=1, mem_rd never asserted. K=5, N=4 → same response.
- Negative result: N=K=1, ker=0x01010101, in=0xFFFFFFFF. Expect out_data 0xFFFFFFFC without the macro, 0x00000000 with CONV1D_CTRL_RELU_EN.
- Reset mid-job: assert rst during the second ACC of the basic job. Expect IDLE next cycle, busy=0, no done, datapath resets low. A restarted job reproduces 62, 18, 1012.
- Start while busy and address wrap: pulse start during a job, which must be ignored. Set in_base=2^AW-1 and verify mem_addr wraps to 0.

Source files
------------

// File: rtl/conv1d_ctrl.sv
// rtl/conv1d_ctrl.sv - sequencing controller for the CONV1D int8 MAC datapath
//
// Purpose: fetches kernel/input words from word-addressed memory, strobes the
// datapath register loads and resets, and emits one accumulator result per
// output position j = 0..N-K over a valid/ready port.
//
// Optional feature macro: CONV1D_CTRL_RELU_EN
//   defined   -> out_data is ReLU(result) (negative results clamp to 0)
//   undefined -> out_data is result unmodified
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     launch job (sampled only in IDLE)
//   in_base, ker_base         word base addresses of input / kernel vectors
//   n_words, k_words          input length N / kernel length K in words
//   mem_addr, mem_rd          memory read address and strobe
//   reg_in_ld, reg_ker_ld,
//   reg_sum_ld                datapath register load strobes
//   alu_rst_n, reg_sum_rst_n  datapath active-low resets
//   result                    datapath accumulator value
//   out_valid, out_ready,
//   out_data, out_idx         result stream (data and output position j)
//   busy, done, err           status: job active, completion pulse, sticky error

module conv1d_ctrl #(
    parameter int AW = 10,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] in_base,
    input  logic [AW-1:0] ker_base,
    input  logic [LW-1:0] n_words,
    input  logic [LW-1:0] k_words,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          reg_in_ld,
    output logic          reg_ker_ld,
    output logic          reg_sum_ld,
    output logic          alu_rst_n,
    output logic          reg_sum_rst_n,
    input  logic [31:0]   result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [LW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RD_KER,
        RD_IN,
        LD_IN,
        ACC,
        WR,
        FIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] j;
    logic [LW-1:0] j_next;
    logic [LW-1:0] k;
    logic [LW-1:0] k_next;
    logic [LW-1:0] n_r;
    logic [LW-1:0] k_r;
    logic [AW-1:0] in_base_r;
    logic [AW-1:0] ker_base_r;
    logic          err_r;

    logic          illegal_len;
    logic          last_k;
    logic          last_j;
    logic [31:0]   result_fmt;

    // K=0 or K>N leaves no valid output position.
    assign illegal_len = (k_words == '0) || (k_words > n_words);

    // Only evaluated once a legal job is running, so K>=1 and N-K>=0.
    assign last_k = (k == (k_r - LW'(1)));
    assign last_j = (j == (n_r - k_r));

`ifdef CONV1D_CTRL_RELU_EN
    assign result_fmt = result[31] ? 32'd0 : result;
`else
    assign result_fmt = result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            j          <= '0;
            k          <= '0;
            n_r        <= '0;
            k_r        <= '0;
            in_base_r  <= '0;
            ker_base_r <= '0;
            err_r      <= 1'b0;
        end else begin
            state <= state_next;
            j     <= j_next;
            k     <= k_next;
            // Parameters are captured once so mid-job input changes are ignored.
            if (state == IDLE && start) begin
                n_r        <= n_words;
                k_r        <= k_words;
                in_base_r  <= in_base;
                ker_base_r <= ker_base;
                err_r      <= illegal_len;
            end
        end
    end

    always_comb begin
        state_next    = state;
        j_next        = j;
        k_next        = k;
        mem_rd        = 1'b0;
        mem_addr      = '0;
        reg_in_ld     = 1'b0;
        reg_ker_ld    = 1'b0;
        reg_sum_ld    = 1'b0;
        alu_rst_n     = 1'b1;
        reg_sum_rst_n = 1'b1;
        out_valid     = 1'b0;
        out_data      = '0;
        out_idx       = '0;
        busy          = (state != IDLE);
        done          = 1'b0;
        err           = err_r;

        case (state)
            IDLE: begin
                if (start) begin
                    if (illegal_len) begin
                        state_next = FIN;
                    end else begin
                        j_next     = '0;
                        state_next = CLR;
                    end
                end
            end
            CLR: begin
                reg_sum_rst_n = 1'b0;
                k_next        = '0;
                state_next    = RD_KER;
            end
            RD_KER: begin
                mem_rd     = 1'b1;
                mem_addr   = ker_base_r + AW'(k);
                state_next = RD_IN;
            end
            RD_IN: begin
                // Kernel word read in RD_KER is on the data bus this cycle.
                reg_ker_ld = 1'b1;
                mem_rd     = 1'b1;
                mem_addr   = in_base_r + AW'(j) + AW'(k);
                state_next = LD_IN;
            end
            LD_IN: begin
                reg_in_ld  = 1'b1;
                state_next = ACC;
            end
            ACC: begin
                reg_sum_ld = 1'b1;
                if (last_k) begin
                    state_next = WR;
                end else begin
                    k_next     = k + LW'(1);
                    state_next = RD_KER;
                end
            end
            WR: begin
                // No datapath strobes here, so result holds while stalled.
                out_valid = 1'b1;
                out_data  = result_fmt;
                out_idx   = j;
                if (out_ready) begin
                    if (last_j) begin
                        state_next = FIN;
                    end else begin
                        j_next     = j + LW'(1);
                        state_next = CLR;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // During reset hold the datapath in reset and silence everything else.
        if (rst) begin
            mem_rd        = 1'b0;
            mem_addr      = '0;
            reg_in_ld     = 1'b0;
            reg_ker_ld    = 1'b0;
            reg_sum_ld    = 1'b0;
            alu_rst_n     = 1'b0;
            reg_sum_rst_n = 1'b0;
            out_valid     = 1'b0;
            out_data      = '0;
            out_idx       = '0;
            busy          = 1'b0;
            done          = 1'b0;
            err           = 1'b0;
        end
    end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// tb/tb_conv1d_ctrl.sv - directed self-checking bench for conv1d_ctrl

module tb_conv1d_ctrl;

    localparam int AW = 10;
    localparam int LW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] in_base;
    logic [AW-1:0] ker_base;
    logic [LW-1:0] n_words;
    logic [LW-1:0] k_words;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          reg_in_ld;
    logic          reg_ker_ld;
    logic          reg_sum_ld;
    logic          alu_rst_n;
    logic          reg_sum_rst_n;
    logic [31:0]   result;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [LW-1:0] out_idx;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    conv1d_ctrl #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_base(in_base), .ker_base(ker_base),
        .n_words(n_words), .k_words(k_words),
        .mem_addr(mem_addr), .mem_rd(mem_rd),
        .reg_in_ld(reg_in_ld), .reg_ker_ld(reg_ker_ld), .reg_sum_ld(reg_sum_ld),
        .alu_rst_n(alu_rst_n), .reg_sum_rst_n(reg_sum_rst_n),
        .result(result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory and datapath environment: registered read, load regs, accumulator.
    logic [31:0] mem [0:1023];
    logic [31:0] mem_q;
    logic [31:0] reg_in_q;
    logic [31:0] reg_ker_q;
    logic [31:0] acc;

    function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
        int s;
        logic signed [7:0] x;
        logic signed [7:0] y;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            s = s + int'(x) * int'(y);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_q <= mem[mem_addr];
        if (!alu_rst_n) begin
            reg_in_q  <= 32'd0;
            reg_ker_q <= 32'd0;
        end else begin
            if (reg_in_ld)  reg_in_q  <= mem_q;
            if (reg_ker_ld) reg_ker_q <= mem_q;
        end
        if (!reg_sum_rst_n) acc <= 32'd0;
        else if (reg_sum_ld) acc <= acc + dot4(reg_in_q, reg_ker_q);
    end
    assign result = acc;

    // Per-job observations gathered by run_job.
    logic [31:0]   res_data [0:7];
    logic [LW-1:0] res_idx  [0:7];
    int res_cnt, first_valid, done_cyc, rd_cnt, overlap, busy_gap, hold_err, addr0_seen;
    bit timed_out;

    task automatic run_job(input logic [LW-1:0] n, input logic [LW-1:0] kk,
                           input logic [AW-1:0] ib, input logic [AW-1:0] kb,
                           input int stall, input int pulse_at);
        int cyc;
        int stall_cnt;
        bit fin;
        logic [31:0]   hd;
        logic [LW-1:0] hi;
        res_cnt = 0; first_valid = -1; done_cyc = -1; rd_cnt = 0; overlap = 0;
        busy_gap = 0; hold_err = 0; addr0_seen = 0;
        hd = '0; hi = '0;
        @(negedge clk);
        n_words = n; k_words = kk; in_base = ib; ker_base = kb;
        start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1; fin = 1'b0; stall_cnt = 0;
        while (!fin && cyc < 400) begin
            out_ready = 1'b0;
            start = 1'b0;
            if (mem_rd) rd_cnt++;
            if (mem_rd && mem_addr == '0) addr0_seen++;
            if (done && out_valid) overlap++;
            if (!busy) busy_gap++;
            if (cyc == pulse_at) begin
                start = 1'b1; in_base = 10'h020; n_words = 8'd4; k_words = 8'd2;
            end
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
            end else if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stall_cnt == 0) begin
                    hd = out_data; hi = out_idx;
                end else if (out_data !== hd || out_idx !== hi) begin
                    hold_err++;
                end
                if (stall_cnt < stall) begin
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                    if (res_cnt < 8) begin
                        res_data[res_cnt] = out_data;
                        res_idx[res_cnt]  = out_idx;
                    end
                    res_cnt++;
                    stall_cnt = 0;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        out_ready = 1'b0;
        start = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        in_base = '0; ker_base = '0; n_words = '0; k_words = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_rd !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: busy=%b done=%b err=%b mem_rd=%b out_valid=%b required all 0", busy, done, err, mem_rd, out_valid); end
        checks++; if (alu_rst_n !== 1'b0 || reg_sum_rst_n !== 1'b0) begin
            errors++; $display("FAIL reset_dp_rst: alu_rst_n=%b reg_sum_rst_n=%b required 0 0", alu_rst_n, reg_sum_rst_n); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (alu_rst_n !== 1'b1 || reg_sum_rst_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: alu_rst_n=%b reg_sum_rst_n=%b busy=%b required 1 1 0", alu_rst_n, reg_sum_rst_n, busy); end
    endtask

    task automatic check_basic_results(input string tag);
        checks++; if (timed_out || res_cnt !== 3) begin
            errors++; $display("FAIL %s_count: got %0d results timeout=%0d required 3", tag, res_cnt, timed_out); end
        checks++; if (res_data[0] !== 32'd62 || res_idx[0] !== 8'd0) begin
            errors++; $display("FAIL %s_out0: got %0d idx %0d required 62 idx 0", tag, res_data[0], res_idx[0]); end
        checks++; if (res_data[1] !== 32'd18 || res_idx[1] !== 8'd1) begin
            errors++; $display("FAIL %s_out1: got %0d idx %0d required 18 idx 1", tag, res_data[1], res_idx[1]); end
        checks++; if (res_data[2] !== 32'd1012 || res_idx[2] !== 8'd2) begin
            errors++; $display("FAIL %s_out2: got %0d idx %0d required 1012 idx 2", tag, res_data[2], res_idx[2]); end
        checks++; if (rd_cnt !== 12) begin
            errors++; $display("FAIL %s_reads: got %0d required 12", tag, rd_cnt); end
        checks++; if (overlap !== 0 || busy_gap !== 0) begin
            errors++; $display("FAIL %s_status: done&valid=%0d busy_gaps=%0d required 0 0", tag, overlap, busy_gap); end
    endtask

    task automatic test_basic();
        run_job(8'd4, 8'd2, 10'h020, 10'h010, 0, 0);
        check_basic_results("basic");
        checks++; if (first_valid !== 10) begin
            errors++; $display("FAIL basic_first_valid: got %0d required 10", first_valid); end
        checks++; if (done_cyc !== 31) begin
            errors++; $display("FAIL basic_done_cycle: got %0d required 31", done_cyc); end
    endtask

    task automatic test_back_pressure();
        run_job(8'd4, 8'd2, 10'h020, 10'h010, 5, 0);
        check_basic_results("bp");
        checks++; if (hold_err !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_err); end
        checks++; if (first_valid !== 10 || done_cyc !== 46) begin
            errors++; $display("FAIL bp_timing: first_valid=%0d done=%0d required 10 46", first_valid, done_cyc); end
    endtask

    task automatic test_illegal();
        run_job(8'd4, 8'd0, 10'h020, 10'h010, 0, 0);
        checks++; if (done_cyc !== 1 || rd_cnt !== 0 || res_cnt !== 0) begin
            errors++; $display("FAIL illegal_k0: done_cyc=%0d reads=%0d results=%0d required 1 0 0", done_cyc, rd_cnt, res_cnt); end
        @(negedge clk);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL illegal_k0_err: err=%b busy=%b required 1 0", err, busy); end
        run_job(8'd4, 8'd5, 10'h020, 10'h010, 0, 0);
        checks++; if (done_cyc !== 1 || rd_cnt !== 0 || res_cnt !== 0) begin
            errors++; $display("FAIL illegal_kgtn: done_cyc=%0d reads=%0d results=%0d required 1 0 0", done_cyc, rd_cnt, res_cnt); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin
            errors++; $display("FAIL illegal_kgtn_err: err=%b required 1", err); end
    endtask

    task automatic test_negative();
        logic [31:0] exp_neg;
`ifdef CONV1D_CTRL_RELU_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'hFFFF_FFFC;
`endif
        run_job(8'd1, 8'd1, 10'h040, 10'h041, 0, 0);
        checks++; if (timed_out || res_cnt !== 1 || res_data[0] !== exp_neg || res_idx[0] !== 8'd0) begin
            errors++; $display("FAIL negative: got %0d results data %h idx %0d required 1 result %h idx 0", res_cnt, res_data[0], res_idx[0], exp_neg); end
        checks++; if (first_valid !== 6 || done_cyc !== 7) begin
            errors++; $display("FAIL negative_timing: first_valid=%0d done=%0d required 6 7", first_valid, done_cyc); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin
            errors++; $display("FAIL err_cleared: err=%b required 0", err); end
    endtask

    task automatic test_reset_mid_job();
        int cyc;
        int bad;
        @(negedge clk);
        n_words = 8'd4; k_words = 8'd2; in_base = 10'h020; ker_base = 10'h010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 9) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (reg_sum_ld !== 1'b1) begin
            errors++; $display("FAIL midrst_acc: reg_sum_ld=%b required 1 at second ACC", reg_sum_ld); end
        rst = 1'b1;
        #1;
        checks++; if (alu_rst_n !== 1'b0 || reg_sum_rst_n !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_comb: alu_rst_n=%b reg_sum_rst_n=%b busy=%b required 0 0 0", alu_rst_n, reg_sum_rst_n, busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: busy=%b out_valid=%b done=%b required 0 0 0", busy, out_valid, done); end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || out_valid || mem_rd) bad++;
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL midrst_quiet: got %0d active cycles required 0", bad); end
        run_job(8'd4, 8'd2, 10'h020, 10'h010, 0, 0);
        check_basic_results("restart");
    endtask

    task automatic test_busy_wrap();
        run_job(8'd2, 8'd1, 10'h3FF, 10'h030, 0, 3);
        checks++; if (timed_out || res_cnt !== 2) begin
            errors++; $display("FAIL wrap_count: got %0d results required 2", res_cnt); end
        checks++; if (res_data[0] !== 32'd10 || res_data[1] !== 32'd26 || res_idx[1] !== 8'd1) begin
            errors++; $display("FAIL wrap_data: got %0d %0d idx %0d required 10 26 idx 1", res_data[0], res_data[1], res_idx[1]); end
        checks++; if (addr0_seen !== 1 || rd_cnt !== 4) begin
            errors++; $display("FAIL wrap_addr: addr0 reads=%0d reads=%0d required 1 4", addr0_seen, rd_cnt); end
        checks++; if (done_cyc !== 13 || busy_gap !== 0) begin
            errors++; $display("FAIL wrap_timing: done=%0d busy_gaps=%0d required 13 0", done_cyc, busy_gap); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_start_ignored: busy=%b required 0 after job", busy); end
    endtask

    initial begin
        mem[10'h010] = 32'h0101_0101;
        mem[10'h011] = 32'h0202_0202;
        mem[10'h020] = 32'h0102_0304;
        mem[10'h021] = 32'h0506_0708;
        mem[10'h022] = 32'hFFFF_FFFF;
        mem[10'h023] = 32'h7F7F_7F7F;
        mem[10'h040] = 32'hFFFF_FFFF;
        mem[10'h041] = 32'h0101_0101;
        mem[10'h030] = 32'h0101_0101;
        mem[10'h3FF] = 32'h0102_0304;
        mem[10'h000] = 32'h0506_0708;

        test_reset();
        test_basic();
        test_back_pressure();
        test_illegal();
        test_negative();
        test_reset_mid_job();
        test_busy_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
